memory_bus_master: RTL

Initiator side of the main-memory RD/WR/ACK bus. Accepts single-word read or write requests from the CPU datapath, latches them, drives the memory strobes, address and write data, and waits for the memory acknowledge. It then returns read data with a one-cycle completion pulse. It sits between the control unit and main memory and owns all memory-bus handshaking.

---
 rtl/memory_bus_master.sv | 114 +++++++++++
 1 files changed

// File: rtl/memory_bus_master.sv
// memory_bus_master: single-word RD/WR/ACK memory-bus initiator (IDLE -> ACCESS -> DONE).
// Define MEMORY_BUS_MASTER_TIMEOUT_EN to build the ACCESS timeout counter and the ERROR path.
module memory_bus_master #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     MEMORY_BUS_MASTER_CLOCK_50,
    input  logic                     MEMORY_BUS_MASTER_RESET_InLow,
    input  logic                     MEMORY_BUS_MASTER_REQ_In,
    input  logic                     MEMORY_BUS_MASTER_WE_In,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_ADDRESS_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_data_InBUS,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_data_OutBUS,
    output logic                     MEMORY_BUS_MASTER_BUSY_Out,
    output logic                     MEMORY_BUS_MASTER_DONE_Out,
    output logic                     MEMORY_BUS_MASTER_ERROR_Out,
    output logic                     MEMORY_BUS_MASTER_MEM_RD_Out,
    output logic                     MEMORY_BUS_MASTER_MEM_WR_Out,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_data_OutBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_data_InBUS,
    input  logic                     MEMORY_BUS_MASTER_MEM_ACK_In
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("memory_bus_master: TIMEOUT_CYCLES must lie in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                   state_q;
    logic                     we_q;
    logic [DATAWIDTH_BUS-1:0] addr_q;
    logic [DATAWIDTH_BUS-1:0] wdata_q;
    logic [DATAWIDTH_BUS-1:0] rdata_q;
`ifdef MEMORY_BUS_MASTER_TIMEOUT_EN
    logic                     err_q;
    logic [7:0]               tmo_cnt_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order inside the block.
    always_ff @(posedge MEMORY_BUS_MASTER_CLOCK_50 or negedge MEMORY_BUS_MASTER_RESET_InLow) begin
        if (!MEMORY_BUS_MASTER_RESET_InLow) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
`ifdef MEMORY_BUS_MASTER_TIMEOUT_EN
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MEMORY_BUS_MASTER_REQ_In) begin
                        we_q      <= MEMORY_BUS_MASTER_WE_In;
                        addr_q    <= MEMORY_BUS_MASTER_ADDRESS_InBUS;
                        wdata_q   <= MEMORY_BUS_MASTER_data_InBUS;
`ifdef MEMORY_BUS_MASTER_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // ACK is tested first so it wins over a timeout on the same edge.
                    if (MEMORY_BUS_MASTER_MEM_ACK_In) begin
                        if (!we_q) begin
                            rdata_q <= MEMORY_BUS_MASTER_MEM_data_InBUS;
                        end
                        state_q <= ST_DONE;
                    end
`ifdef MEMORY_BUS_MASTER_TIMEOUT_EN
                    else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                ST_DONE: begin
`ifdef MEMORY_BUS_MASTER_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes are decoded from registered state so reset removes them without a clock.
    assign MEMORY_BUS_MASTER_BUSY_Out           = (state_q != ST_IDLE);
    assign MEMORY_BUS_MASTER_DONE_Out           = (state_q == ST_DONE);
    assign MEMORY_BUS_MASTER_MEM_RD_Out         = (state_q == ST_ACCESS) && !we_q;
    assign MEMORY_BUS_MASTER_MEM_WR_Out         = (state_q == ST_ACCESS) &&  we_q;
    assign MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS = addr_q;
    assign MEMORY_BUS_MASTER_MEM_data_OutBUS    = wdata_q;
    assign MEMORY_BUS_MASTER_data_OutBUS        = rdata_q;
`ifdef MEMORY_BUS_MASTER_TIMEOUT_EN
    assign MEMORY_BUS_MASTER_ERROR_Out          = err_q;
`else
    assign MEMORY_BUS_MASTER_ERROR_Out          = 1'b0;
`endif

endmodule
